// File: rtl/clock_select_sequencer_pkg.sv
// Shared types and helpers for the N-way break-before-make clock-select sequencer.
package clock_select_pkg;

  localparam int unsigned MAXCLK = 16;

  typedef enum logic [1:0] {IDLE, GAP, HOLD} state_t;

  function automatic logic [MAXCLK-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAXCLK-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAXCLK; i++) begin
      v[i] = (i == idx) && (i < n);
    end
    return v;
  endfunction

  // Counter must hold GAPDELAY-1 and RSTDELAY; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned gap, input int unsigned rdly);
    int unsigned m;
    m = (gap > rdly + 1) ? gap : rdly + 1;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/clock_select_sequencer_sel_onehot_decode.sv
// Registered index-to-one-hot decoder producing the external clock-gate enables.
module sel_onehot_decode
  import clock_select_pkg::*;
#(
  parameter int NCLK     = 4,
  parameter int SELW     = 2,
  parameter int INIT_SEL = 0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clear,
  input  logic            i_load,
  input  logic [SELW-1:0] i_idx,
  output logic [NCLK-1:0] o_onehot
);

  localparam logic [MAXCLK-1:0] RST_FULL = onehot(INIT_SEL, NCLK);

  logic [NCLK-1:0] w_oh;

  always_comb begin
    w_oh = '0;
    for (int unsigned i = 0; i < NCLK; i++) begin
      w_oh[i] = (32'(i_idx) == i);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_onehot <= RST_FULL[NCLK-1:0];
    end else if (i_clear) begin
      o_onehot <= '0;
    end else if (i_load) begin
      o_onehot <= w_oh;
    end
  end

endmodule

// File: rtl/clock_select_sequencer.sv
// Break-before-make clock-source sequencer: gap with all enables low, switch, then hold
// the downstream reset before returning to idle.
module clock_select_sequencer
  import clock_select_pkg::*;
#(
  parameter int NCLK     = 4,
  parameter int SELW     = 2,
  parameter int GAPDELAY = 4,
  parameter int RSTDELAY = 2,
  parameter int INIT_SEL = 0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [SELW-1:0] SELECT,
  input  logic            SELECT_ENABLE,
  output logic            SELECT_READY,
  output logic [NCLK-1:0] CLK_EN,
  output logic [SELW-1:0] CUR_SEL,
  output logic            OUT_RST,
  output logic            SEL_ERR
);

  localparam int unsigned     CNTW     = cnt_width(GAPDELAY, RSTDELAY);
  localparam logic [CNTW-1:0] GAP_LOAD = CNTW'(GAPDELAY - 1);
  localparam logic [CNTW-1:0] RST_LOAD = CNTW'(RSTDELAY);
  localparam logic [SELW:0]   NCLK_LIM = (SELW + 1)'(NCLK);
  localparam logic [SELW-1:0] INIT_IDX = SELW'(INIT_SEL);

  state_t          r_state, w_state;
  logic [CNTW-1:0] r_cnt, w_cnt;
  logic [SELW-1:0] r_target, w_target;
  logic [SELW-1:0] r_cur_sel, w_cur_sel;
  logic            r_out_rst, w_out_rst;
  logic            r_ready, w_ready;
  logic            r_sel_err, w_sel_err;
  logic            w_en_clear, w_en_load;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= HOLD;
      r_cnt     <= RST_LOAD;
      r_target  <= INIT_IDX;
      r_cur_sel <= INIT_IDX;
      r_out_rst <= 1'b0;
      r_ready   <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_target  <= w_target;
      r_cur_sel <= w_cur_sel;
      r_out_rst <= w_out_rst;
      r_ready   <= w_ready;
      r_sel_err <= w_sel_err;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_target   = r_target;
    w_cur_sel  = r_cur_sel;
    w_out_rst  = r_out_rst;
    w_sel_err  = 1'b0;
    w_en_clear = 1'b0;
    w_en_load  = 1'b0;
    case (r_state)
      IDLE: begin
        if (SELECT_ENABLE) begin
          if ({1'b0, SELECT} >= NCLK_LIM) begin
            w_sel_err = 1'b1;
          end else if (SELECT != r_cur_sel) begin
            w_target   = SELECT;
            w_en_clear = 1'b1;
            w_out_rst  = 1'b0;
            w_cnt      = GAP_LOAD;
            w_state    = GAP;
          end
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_en_load = 1'b1;
          w_cur_sel = r_target;
          w_cnt     = RST_LOAD;
          w_state   = HOLD;
        end else begin
          w_cnt = r_cnt - CNTW'(1);
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_out_rst = 1'b1;
          w_state   = IDLE;
        end else begin
          w_cnt = r_cnt - CNTW'(1);
        end
      end
      default: begin
        w_out_rst = 1'b0;
        w_cnt     = RST_LOAD;
        w_state   = HOLD;
      end
    endcase
    // READY is registered alongside the state so it matches state==IDLE with no input path.
    w_ready = (w_state == IDLE);
  end

  sel_onehot_decode #(
    .NCLK     (NCLK),
    .SELW     (SELW),
    .INIT_SEL (INIT_SEL)
  ) u_decode (
    .i_clk    (CLK),
    .i_rst_n  (RST),
    .i_clear  (w_en_clear),
    .i_load   (w_en_load),
    .i_idx    (r_target),
    .o_onehot (CLK_EN)
  );

  assign SELECT_READY = r_ready;
  assign CUR_SEL      = r_cur_sel;
  assign OUT_RST      = r_out_rst;
  assign SEL_ERR      = r_sel_err;

endmodule

// File: tb/tb_clock_select_sequencer.sv
// Bench for clock_select_sequencer: directed scenarios plus random requests against a
// timeline model of the switch sequence.
module tb_clock_select_sequencer;

  localparam int G = 4;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sel = '0;
  logic       sel_en = 1'b0;
  logic       ready, out_rst, sel_err;
  logic [3:0] clk_en;
  logic [1:0] cur;

  logic [1:0] sel3 = '0;
  logic       en3 = 1'b0;
  logic       ready3, out_rst3, err3;
  logic [2:0] clk_en3;
  logic [1:0] cur3;

  int errors = 0;
  int checks = 0;
  logic mon_on = 1'b0;

  always #5 clk = ~clk;

  clock_select_sequencer #(.NCLK(4), .SELW(2), .GAPDELAY(G), .RSTDELAY(R), .INIT_SEL(0)) dut (
    .CLK(clk), .RST(rst_n), .SELECT(sel), .SELECT_ENABLE(sel_en), .SELECT_READY(ready),
    .CLK_EN(clk_en), .CUR_SEL(cur), .OUT_RST(out_rst), .SEL_ERR(sel_err)
  );

  clock_select_sequencer #(.NCLK(3), .SELW(2), .GAPDELAY(G), .RSTDELAY(R), .INIT_SEL(0)) dut3 (
    .CLK(clk), .RST(rst_n), .SELECT(sel3), .SELECT_ENABLE(en3), .SELECT_READY(ready3),
    .CLK_EN(clk_en3), .CUR_SEL(cur3), .OUT_RST(out_rst3), .SEL_ERR(err3)
  );

  // Timeline model: edge count m_e; a change accepted at edge T blanks enables for
  // edges T..T+G-1, switches at T+G, and releases reset/ready at T+G+R+1.
  int m_e = 0, m_ready_at = R + 1, m_sw_at = 0, m_gap_from = 0, m_old = 0, m_tgt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_old      <= 0;
      m_tgt      <= 0;
      m_gap_from <= 0;
      m_sw_at    <= 0;
      m_ready_at <= m_e + R + 1;
    end else begin
      m_e <= m_e + 1;
      if (m_e >= m_ready_at && sel_en && int'(sel) != m_tgt) begin
        m_old      <= m_tgt;
        m_tgt      <= int'(sel);
        m_gap_from <= m_e + 1;
        m_sw_at    <= m_e + 1 + G;
        m_ready_at <= m_e + 1 + G + R + 1;
      end
    end
  end

  function automatic logic [3:0] exp_en();
    logic [3:0] v;
    v = 4'b0001;
    if (m_e >= m_gap_from && m_e < m_sw_at) return 4'b0000;
    return v << ((m_e >= m_sw_at) ? m_tgt : m_old);
  endfunction

  function automatic logic [1:0] exp_cur();
    return 2'((m_e >= m_sw_at) ? m_tgt : m_old);
  endfunction

  function automatic logic exp_rdy();
    return m_e >= m_ready_at;
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      checks++;
      if (clk_en !== exp_en()) begin
        errors++; $display("FAIL model_clk_en t=%0t got=%b exp=%b", $time, clk_en, exp_en());
      end
      checks++;
      if (cur !== exp_cur()) begin
        errors++; $display("FAIL model_cur_sel t=%0t got=%0d exp=%0d", $time, cur, exp_cur());
      end
      checks++;
      if (out_rst !== exp_rdy()) begin
        errors++; $display("FAIL model_out_rst t=%0t got=%b exp=%b", $time, out_rst, exp_rdy());
      end
      checks++;
      if (ready !== exp_rdy()) begin
        errors++; $display("FAIL model_ready t=%0t got=%b exp=%b", $time, ready, exp_rdy());
      end
      checks++;
      if (sel_err !== 1'b0) begin
        errors++; $display("FAIL model_sel_err t=%0t got=%b exp=0", $time, sel_err);
      end
      checks++;
      if ($countones(clk_en) > 1) begin
        errors++; $display("FAIL onehot_invariant t=%0t got=%b exp=at most one bit", $time, clk_en);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; sel_en = 1'b0; en3 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (clk_en !== 4'b0001) begin errors++; $display("FAIL rst_clk_en got=%b exp=0001", clk_en); end
    checks++; if (cur !== 2'd0) begin errors++; $display("FAIL rst_cur got=%0d exp=0", cur); end
    checks++; if (out_rst !== 1'b0) begin errors++; $display("FAIL rst_out_rst got=%b exp=0", out_rst); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", ready); end
    checks++; if (clk_en3 !== 3'b001) begin errors++; $display("FAIL rst_clk_en3 got=%b exp=001", clk_en3); end
    #2 rst_n = 1'b1;
    mon_on = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++; if (out_rst !== 1'b0) begin errors++; $display("FAIL rel_out_rst_e%0d got=%b exp=0", k, out_rst); end
    end
    @(negedge clk);
    checks++; if (out_rst !== 1'b1) begin errors++; $display("FAIL rel_out_rst_e3 got=%b exp=1", out_rst); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rel_ready_e3 got=%b exp=1", ready); end
  endtask

  task automatic test_switch();
    @(negedge clk); sel = 2'd2; sel_en = 1'b1;
    @(negedge clk); sel_en = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (clk_en !== 4'b0000) begin errors++; $display("FAIL sw_gap_T+%0d got=%b exp=0000", k, clk_en); end
    end
    @(negedge clk);
    checks++; if (clk_en !== 4'b0100) begin errors++; $display("FAIL sw_en_T+4 got=%b exp=0100", clk_en); end
    checks++; if (cur !== 2'd2) begin errors++; $display("FAIL sw_cur got=%0d exp=2", cur); end
    repeat (2) @(negedge clk);
    checks++; if (out_rst !== 1'b0) begin errors++; $display("FAIL sw_out_rst_T+6 got=%b exp=0", out_rst); end
    @(negedge clk);
    checks++; if (out_rst !== 1'b1) begin errors++; $display("FAIL sw_out_rst_T+7 got=%b exp=1", out_rst); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL sw_ready_T+7 got=%b exp=1", ready); end
  endtask

  task automatic test_same();
    @(negedge clk); sel = 2'd2; sel_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (clk_en !== 4'b0100 || out_rst !== 1'b1 || ready !== 1'b1 || sel_err !== 1'b0) begin
        errors++; $display("FAIL same_noop got=en%b rst%b rdy%b err%b exp=en0100 rst1 rdy1 err0", clk_en, out_rst, ready, sel_err);
      end
    end
    sel_en = 1'b0;
  endtask

  task automatic test_select_error();
    @(negedge clk); sel3 = 2'd3; en3 = 1'b1;
    @(negedge clk); en3 = 1'b0;
    checks++; if (err3 !== 1'b1) begin errors++; $display("FAIL err_pulse got=%b exp=1", err3); end
    checks++; if (clk_en3 !== 3'b001 || cur3 !== 2'd0) begin errors++; $display("FAIL err_unchanged got=en%b cur%0d exp=en001 cur0", clk_en3, cur3); end
    @(negedge clk);
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL err_one_cycle got=%b exp=0", err3); end
    checks++; if (ready3 !== 1'b1 || out_rst3 !== 1'b1) begin errors++; $display("FAIL err_ready got=rdy%b rst%b exp=rdy1 rst1", ready3, out_rst3); end
  endtask

  task automatic test_ignore_during_gap();
    int n;
    @(negedge clk); sel = 2'd3; sel_en = 1'b1;
    @(negedge clk); sel = 2'd1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    checks++; if (clk_en !== 4'b1000) begin errors++; $display("FAIL gap_ignore_en got=%b exp=1000", clk_en); end
    n = 0;
    while (!(ready === 1'b1 && clk_en === 4'b0010) && n < 40) begin @(negedge clk); n++; end
    sel_en = 1'b0;
    checks++; if (clk_en !== 4'b0010 || cur !== 2'd1) begin errors++; $display("FAIL held_req got=en%b cur%0d exp=en0010 cur1", clk_en, cur); end
  endtask

  task automatic test_reset_abort();
    int n;
    @(negedge clk); sel = 2'd0; sel_en = 1'b1;
    @(negedge clk); sel_en = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (clk_en !== 4'b0001) begin errors++; $display("FAIL abort_pre got=%b exp=0001", clk_en); end
    @(negedge clk); sel = 2'd3; sel_en = 1'b1;
    @(negedge clk); sel_en = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (clk_en !== 4'b0001 || out_rst !== 1'b0 || ready !== 1'b0 || cur !== 2'd0) begin
      errors++; $display("FAIL abort_state got=en%b rst%b rdy%b cur%0d exp=en0001 rst0 rdy0 cur0", clk_en, out_rst, ready, cur);
    end
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_rst !== 1'b0) begin errors++; $display("FAIL abort_rel_e2 got=%b exp=0", out_rst); end
    @(negedge clk);
    checks++; if (out_rst !== 1'b1 || clk_en !== 4'b0001) begin errors++; $display("FAIL abort_rel_e3 got=rst%b en%b exp=rst1 en0001", out_rst, clk_en); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      sel    = 2'($urandom_range(0, 3));
      sel_en = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk); sel_en = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_switch();
    test_same();
    test_select_error();
    test_ignore_during_gap();
    test_reset_abort();
    test_random();
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
